fifo_stream_reader: RTL and testbench

// - Read-side controller for the 4-bit standard-mode FIFO (1-cycle read latency, non-FWFT).
// - Pops words from the FIFO at a paced rate and presents them as a valid/ready stream,

---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 117 +++++++++++
 tb/tb_fifo_stream_reader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of the
// FIFO stream reader. The master side is the reader; the slave side is the
// FIFO plus the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 4
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a 1-cycle-latency (non-FWFT) FIFO. Pops words at a
// paced rate and presents them as a valid/ready stream through a 2-entry skid
// buffer, so downstream backpressure can never cause the FIFO to be overread.
module fifo_stream_reader #(
  parameter int DATA_W  = 4,
  parameter int CNT_W   = 16,
  parameter int PACE_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                tick,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]    words_read,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;

  logic              pop;
  logic              pace_ok;
  logic              rd_en;
  logic [2:0]        fill_sum;
  logic [2:0]        fill_lim;

  assign pop      = bus.m_valid & bus.m_ready;
  assign pace_ok  = (PACE_EN == 0) | tick;

  // occ + inflight - pop <= 1, rearranged to stay unsigned.
  assign fill_sum = {1'b0, occ} + {2'b00, inflight};
  assign fill_lim = 3'd1 + {2'b00, pop};

  assign rd_en = ~reset & (state == RUN) & ~bus.fifo_empty & pace_ok &
                 (fill_sum <= fill_lim);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = buf0;
  assign busy           = (state != IDLE);

  // Control FSM: a read issued on the cycle enable drops still counts as
  // pending work, so the FSM goes through FLUSH to capture it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            if ((occ != 2'd0) || inflight || rd_en) state <= FLUSH;
            else                                    state <= IDLE;
          end
        end
        FLUSH: begin
          if (enable)                              state <= RUN;
          else if ((occ == 2'd0) && !inflight)     state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the word in the FIFO's 1-cycle read pipe; a read issued just
  // before reset is dropped here.
  always_ff @(posedge clk) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= rd_en;
  end

  // Skid buffer: buf0 is the head; captures go to the tail, pops shift
  // buf1 forward so strict FIFO order is preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= bus.fifo_dout;
          else             buf1 <= bus.fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= bus.fifo_dout;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.fifo_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Count accepted transfers, wrapping freely.
  always_ff @(posedge clk) begin
    if (reset)    words_read <= '0;
    else if (pop) words_read <= words_read + CNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one paced instance and one unpaced instance,
// each fed by a small behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;

  logic        clk;
  logic        reset;
  logic        p_en, p_tick, f_en, f_tick;
  logic [15:0] p_words, f_words;
  logic        p_busy, f_busy;

  int checks   = 0;
  int failures = 0;

  fifo_stream_reader_if #(.DATA_W(4)) p_bus ();
  fifo_stream_reader_if #(.DATA_W(4)) f_bus ();

  fifo_stream_reader #(.DATA_W(4), .CNT_W(16), .PACE_EN(1)) u_pace (
    .clk        (clk),
    .reset      (reset),
    .enable     (p_en),
    .tick       (p_tick),
    .bus        (p_bus),
    .words_read (p_words),
    .busy       (p_busy)
  );

  fifo_stream_reader #(.DATA_W(4), .CNT_W(16), .PACE_EN(0)) u_fast (
    .clk        (clk),
    .reset      (reset),
    .enable     (f_en),
    .tick       (f_tick),
    .bus        (f_bus),
    .words_read (f_words),
    .busy       (f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFOs
  logic [3:0]  p_mem [256];
  logic [3:0]  f_mem [256];
  logic [31:0] p_wr = 32'd0;
  logic [31:0] p_rd = 32'd0;
  logic [31:0] f_wr = 32'd0;
  logic [31:0] f_rd = 32'd0;

  assign p_bus.fifo_empty = (p_wr == p_rd);
  assign f_bus.fifo_empty = (f_wr == f_rd);

  initial begin
    p_bus.fifo_dout = 4'h0;
    f_bus.fifo_dout = 4'h0;
  end

  always @(posedge clk) begin
    if (p_bus.fifo_rd_en) begin
      p_bus.fifo_dout <= p_mem[p_rd[7:0]];
      p_rd            <= p_rd + 32'd1;
    end
  end

  always @(posedge clk) begin
    if (f_bus.fifo_rd_en) begin
      f_bus.fifo_dout <= f_mem[f_rd[7:0]];
      f_rd            <= f_rd + 32'd1;
    end
  end

  task automatic load_p(input logic [3:0] v);
    p_mem[p_wr[7:0]] = v;
    p_wr = p_wr + 32'd1;
  endtask

  task automatic load_f(input logic [3:0] v);
    f_mem[f_wr[7:0]] = v;
    f_wr = f_wr + 32'd1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        tick;
    logic        exp_rd;
    logic        exp_vld;
    logic [3:0]  exp_data;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t tbl [17];

  logic [3:0] seq_b [5];
  int         rd_cnt;
  int         cyc;
  logic       found;

  initial begin
    // Paced read of 3,5,A with tick on every cycle k where k%4==3.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'h3, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'h5, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd2};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd2};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'hA, 16'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd3};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 4'h0, 16'd3};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'd3};

    seq_b[0] = 4'h6; seq_b[1] = 4'h7; seq_b[2] = 4'h8; seq_b[3] = 4'h9; seq_b[4] = 4'hA;

    reset = 1'b1;
    p_en = 1'b0; p_tick = 1'b0; f_en = 1'b0; f_tick = 1'b0;
    p_bus.m_ready = 1'b1;
    f_bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_f_valid", 32'(f_bus.m_valid), 32'd0);
    check("rst_f_data",  32'(f_bus.m_data),  32'd0);
    check("rst_f_words", 32'(f_words),       32'd0);
    check("rst_f_busy",  32'(f_busy),        32'd0);
    check("rst_p_rd_en", 32'(p_bus.fifo_rd_en), 32'd0);

    // Paced reads from the table
    load_p(4'h3); load_p(4'h5); load_p(4'hA);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      p_en   = 1'b1;
      p_tick = tbl[k].tick;
      #1;
      check($sformatf("pace_rd_en[%0d]", k), 32'(p_bus.fifo_rd_en), 32'(tbl[k].exp_rd));
      check($sformatf("pace_valid[%0d]", k), 32'(p_bus.m_valid),    32'(tbl[k].exp_vld));
      check($sformatf("pace_words[%0d]", k), 32'(p_words),          32'(tbl[k].exp_wr));
      if (tbl[k].exp_vld)
        check($sformatf("pace_data[%0d]", k), 32'(p_bus.m_data), 32'(tbl[k].exp_data));
    end

    // Empty FIFO with tick toggling: never read, never valid
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      p_tick = ~p_tick;
      #1;
      check($sformatf("empty_rd_en[%0d]", k), 32'(p_bus.fifo_rd_en), 32'd0);
      check($sformatf("empty_valid[%0d]", k), 32'(p_bus.m_valid),    32'd0);
    end
    p_tick = 1'b0;

    // Backpressure: 5 words, m_ready=0 -> exactly 2 reads, head held
    @(negedge clk);
    load_f(4'h6); load_f(4'h7); load_f(4'h8); load_f(4'h9); load_f(4'hA);
    f_bus.m_ready = 1'b0;
    f_en = 1'b1;
    #1;
    rd_cnt = int'(f_bus.fifo_rd_en);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      rd_cnt += int'(f_bus.fifo_rd_en);
    end
    check("bp_read_count", 32'(rd_cnt),        32'd2);
    check("bp_valid",      32'(f_bus.m_valid), 32'd1);
    check("bp_head",       32'(f_bus.m_data),  32'h6);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      f_bus.m_ready = 1'b1;
      #1;
      check($sformatf("drain_valid[%0d]", k), 32'(f_bus.m_valid), 32'd1);
      check($sformatf("drain_data[%0d]", k),  32'(f_bus.m_data),  32'(seq_b[k]));
    end
    @(negedge clk);
    #1;
    check("drain_done_valid", 32'(f_bus.m_valid), 32'd0);
    check("drain_words",      32'(f_words),       32'd5);

    // Drop enable with occ=1 and inflight=1
    @(negedge clk);
    f_bus.m_ready = 1'b0;
    load_f(4'hB); load_f(4'hC); load_f(4'hD);
    #1;
    check("fl_rd0", 32'(f_bus.fifo_rd_en), 32'd1);
    @(negedge clk);
    #1;
    check("fl_rd1", 32'(f_bus.fifo_rd_en), 32'd1);
    @(negedge clk);
    f_en = 1'b0;
    #1;
    check("fl_rd2",   32'(f_bus.fifo_rd_en), 32'd0);
    check("fl_head2", 32'(f_bus.m_data),     32'hB);
    @(negedge clk);
    #1;
    check("fl_busy3",  32'(f_busy),           32'd1);
    check("fl_rd3",    32'(f_bus.fifo_rd_en), 32'd0);
    check("fl_valid3", 32'(f_bus.m_valid),    32'd1);
    @(negedge clk);
    f_bus.m_ready = 1'b1;
    #1;
    check("fl_data4", 32'(f_bus.m_data),     32'hB);
    check("fl_rd4",   32'(f_bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    #1;
    check("fl_data5",  32'(f_bus.m_data),     32'hC);
    check("fl_valid5", 32'(f_bus.m_valid),    32'd1);
    @(negedge clk);
    #1;
    check("fl_valid6", 32'(f_bus.m_valid),    32'd0);
    check("fl_rd6",    32'(f_bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    #1;
    check("fl_busy7",  32'(f_busy),           32'd0);
    check("fl_rd7",    32'(f_bus.fifo_rd_en), 32'd0);
    check("fl_words7", 32'(f_words),          32'd7);

    // Reset mid-stream with occ=2
    @(negedge clk);
    f_en = 1'b1;
    f_bus.m_ready = 1'b0;
    load_f(4'hE); load_f(4'hF);
    repeat (4) @(negedge clk);
    #1;
    check("mr_valid_pre", 32'(f_bus.m_valid), 32'd1);
    check("mr_head_pre",  32'(f_bus.m_data),  32'hD);
    reset = 1'b1;
    #1;
    check("mr_rd_in_reset", 32'(f_bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    f_wr = f_rd + 32'd100000;
    f_bus.m_ready = 1'b1;
    #1;
    check("mr_valid", 32'(f_bus.m_valid),    32'd0);
    check("mr_data",  32'(f_bus.m_data),     32'd0);
    check("mr_busy",  32'(f_busy),           32'd0);
    check("mr_words", 32'(f_words),          32'd0);
    check("mr_rd_en", 32'(f_bus.fifo_rd_en), 32'd0);
    check("mr_pbusy", 32'(p_busy),           32'd0);

    // Counter wrap with a continuously non-empty FIFO
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 70000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (f_words == 16'hFFFF) found = 1'b1;
    end
    check("wrap_reached", 32'(found), 32'd1);
    check("wrap_cycles",  32'(cyc),   32'd65538);
    check("wrap_valid",   32'(f_bus.m_valid), 32'd1);
    @(negedge clk);
    #1;
    check("wrap_zero", 32'(f_words), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
